hilo_muldiv_ctrl: RTL and testbench
===================================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  EX/MEM-side consumer of the ALU's multiply/divide results. Owns the architectural HI/LO
//  registers, sequences the multi-cycle divide (stall, wait, commit), and serves MTHI/MTLO/MFHI/MFLO.
//  Sits directly downstream of the ALU: consumes Result1 (LO part) / Result2 (HI part) and drives the pipeline stall.
// PARAMETERS
//  DIV_LATENCY  34  cycles from divide accept to ALU quotient/remainder valid (32-stage divider + in/out regs)
//  CNT_W        6   width of divide wait counter; must hold DIV_LATENCY-1
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, synchronous, active-low
//  flush        in   1   exception flush; cancels any op in flight
//  op_valid     in   1   op_code valid this cycle
//  op_code      in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MADD/MSUB (see CONFIGURATION)
//  op_sub       in   1   with op 7: 0 MADD, 1 MSUB; ignored otherwise
//  hold         in   1   downstream stall; no commit, no state advance while high (counter still runs)
//  alu_res_lo   in   32  ALU Result1 (product low / quotient)
//  alu_res_hi   in   32  ALU Result2 (product high / remainder)
//  rs_data      in   32  source value for MTHI/MTLO
//  hi_o         out  32  architectural HI (registered)
//  lo_o         out  32  architectural LO (registered)
//  stall_req    out  1   request upstream freeze (combinational from state)
//  div_done     out  1   one-cycle pulse on divide commit
// BEHAVIOUR
//  - Reset (rst==0 at posedge): hi_o=0, lo_o=0, state=IDLE, counter=0, div_done=0; stall_req=0 after reset.
//  - States: IDLE, DIV_BUSY, DIV_COMMIT.
//  - Accept = op_valid & ~hold & ~flush & state==IDLE. Ops presented in other states are ignored (upstream is stalled).
//  - MULT/MULTU accept: same edge HI<=alu_res_hi, LO<=alu_res_lo; latency 1; stall_req stays 0.
//  - MTHI: HI<=rs_data; MTLO: LO<=rs_data; the other register is unchanged.
//  - DIV/DIVU accept: state->DIV_BUSY, counter<=DIV_LATENCY-1; stall_req=1 from next cycle.
//  - DIV_BUSY: counter decrements each cycle; at counter==0 -> DIV_COMMIT. stall_req=1.
//  - DIV_COMMIT: if ~hold: LO<=alu_res_lo (quotient), HI<=alu_res_hi (remainder), div_done=1 for this cycle,
//    ->IDLE; stall_req=0 in this cycle so the next op issues next edge. If hold: remain, stall_req=1.
//  - Divide by zero: no trap; whatever the ALU produces is committed.
//  - flush: highest priority, overriding any accept. In any state: ->IDLE, counter<=0, no HI/LO write,
//    div_done=0. flush and op_valid in the same cycle: op dropped.
//  - rst low mid-divide: same as reset; divider output discarded.
//  - hi_o/lo_o change only on a commit edge; readers (MFHI/MFLO) see the new value the following cycle.
// CONFIGURATION
//  MADD_MSUB_EN defined: op 7 accepted; {HI,LO} <= {HI,LO} +/- {alu_res_hi,alu_res_lo} (64-bit, wraps mod 2^64,
//    ALU set to signed multiply by decode); latency 1, no stall.
//  MADD_MSUB_EN undefined: op 7 treated as NONE (no write, no stall); op_sub unused.
// STRUCTURE
//  - Package muldiv_pkg: op_code encodings, state encoding, DIV_LATENCY default.
//  - Sub-module hilo_regs: 2x32 registers with independent write enables and write data muxes;
//    top module holds FSM, counter and accumulator adder.
// TESTING
//  - MULT, alu_res_hi=0xFFFFFFFF, alu_res_lo=0xFFFFFFFE -> next cycle hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE, stall_req never 1.
//  - DIVU accepted at cycle 0, res_lo=7, res_hi=3 -> stall_req=1 cycles 1..34, div_done=1 at cycle 35, hi_o=3, lo_o=7 at 36.
//  - flush asserted at cycle 10 of a DIV -> state IDLE next cycle, stall_req=0, hi_o/lo_o unchanged, no div_done.
//  - hold held high 5 cycles in DIV_COMMIT -> stall_req stays 1, single div_done only when hold drops.
//  - MTHI rs_data=0x12345678 then MTLO rs_data=0x9ABCDEF0 -> hi_o=0x12345678, lo_o=0x9ABCDEF0; op during DIV_BUSY ignored.
//  - MADD_MSUB_EN: HI:LO=0x0:0xFFFFFFFF, MADD res 0x0:0x1 -> 0x1:0x0; without macro HI:LO unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encodings and defaults for the HI/LO mul/div controller.
// MADD_MSUB_EN enables op 7 (multiply-accumulate) in hilo_muldiv_ctrl.
package muldiv_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
  localparam logic [2:0] OP_MACC  = 3'd7;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  localparam int DIV_LATENCY_DEF = 34;
  localparam int CNT_W_DEF       = 6;

  typedef enum logic [1:0] {
    SRC_ALU,
    SRC_RS,
    SRC_ACC
  } src_t;

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair with independent
// write enables and per-register write-data source select.
module hilo_regs
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hi_we,
  input  logic        lo_we,
  input  src_t        hi_sel,
  input  src_t        lo_sel,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  input  logic [31:0] rs_data,
  input  logic [31:0] acc_hi,
  input  logic [31:0] acc_lo,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_wd;
  logic [31:0] lo_wd;

  always_comb begin
    hi_wd = alu_hi;
    unique case (hi_sel)
      SRC_RS:  hi_wd = rs_data;
      SRC_ACC: hi_wd = acc_hi;
      default: hi_wd = alu_hi;
    endcase
  end

  always_comb begin
    lo_wd = alu_lo;
    unique case (lo_sel)
      SRC_RS:  lo_wd = rs_data;
      SRC_ACC: lo_wd = acc_lo;
      default: lo_wd = alu_lo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_wd;
      if (lo_we) lo <= lo_wd;
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: mult/mthi/mtlo commit, multi-cycle divide sequencing.
// Optional MADD/MSUB accumulate path under `define MADD_MSUB_EN.
module hilo_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic        op_sub,
  input  logic        hold,
  input  logic [31:0] alu_res_lo,
  input  logic [31:0] alu_res_hi,
  input  logic [31:0] rs_data,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall_req,
  output logic        div_done
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  logic accept;
  logic commit;
  logic is_mul;
  logic is_div;
  logic is_mthi;
  logic is_mtlo;
  logic is_macc;

  logic hi_we;
  logic lo_we;
  src_t hi_sel;
  src_t lo_sel;

  logic [63:0] acc;

  assign accept = op_valid & ~hold & ~flush
                & (state == S_IDLE);
  assign commit = (state == S_COMMIT)
                & ~hold & ~flush;

  assign is_mul  = (op_code == OP_MULT)
                 | (op_code == OP_MULTU);
  assign is_div  = (op_code == OP_DIV)
                 | (op_code == OP_DIVU);
  assign is_mthi = (op_code == OP_MTHI);
  assign is_mtlo = (op_code == OP_MTLO);

`ifdef MADD_MSUB_EN
  logic [63:0] hilo;
  logic [63:0] prod;

  assign is_macc = (op_code == OP_MACC);
  assign hilo    = {hi_o, lo_o};
  assign prod    = {alu_res_hi, alu_res_lo};
  // Wraps mod 2^64 by construction of the 64-bit add/sub
  assign acc     = op_sub ? hilo - prod
                          : hilo + prod;
`else
  logic unused_sub;

  assign is_macc    = 1'b0;
  assign acc        = {hi_o, lo_o};
  assign unused_sub = op_sub;
`endif

  assign stall_req = (state == S_BUSY)
                   | ((state == S_COMMIT) & hold);
  assign div_done  = commit;

  always_comb begin
    hi_we  = 1'b0;
    lo_we  = 1'b0;
    hi_sel = SRC_ALU;
    lo_sel = SRC_ALU;
    if (commit) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
    end else if (accept) begin
      unique case (1'b1)
        is_mul: begin
          hi_we = 1'b1;
          lo_we = 1'b1;
        end
        is_mthi: begin
          hi_we  = 1'b1;
          hi_sel = SRC_RS;
        end
        is_mtlo: begin
          lo_we  = 1'b1;
          lo_sel = SRC_RS;
        end
        is_macc: begin
          hi_we  = 1'b1;
          lo_we  = 1'b1;
          hi_sel = SRC_ACC;
          lo_sel = SRC_ACC;
        end
        default: ;
      endcase
    end
  end

  // Counter keeps running under hold; only the state edge waits
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept && is_div) begin
            state <= S_BUSY;
            cnt   <= CNT_W'(DIV_LATENCY - 1);
          end
        end
        S_BUSY: begin
          if (cnt != '0)
            cnt <= cnt - 1'b1;
          else if (!hold)
            state <= S_COMMIT;
        end
        S_COMMIT: begin
          if (!hold) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  hilo_regs u_regs (
    .clk     (clk),
    .rst     (rst),
    .hi_we   (hi_we),
    .lo_we   (lo_we),
    .hi_sel  (hi_sel),
    .lo_sel  (lo_sel),
    .alu_hi  (alu_res_hi),
    .alu_lo  (alu_res_lo),
    .rs_data (rs_data),
    .acc_hi  (acc[63:32]),
    .acc_lo  (acc[31:0]),
    .hi      (hi_o),
    .lo      (lo_o)
  );

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: mult, mthi/mtlo,
// divide timing, flush, hold, back-to-back, reset, MADD/MSUB.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        op_valid;
  logic [2:0]  op_code;
  logic        op_sub;
  logic        hold;
  logic [31:0] alu_res_lo;
  logic [31:0] alu_res_hi;
  logic [31:0] rs_data;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stall_req;
  logic        div_done;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  hilo_muldiv_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .op_sub     (op_sub),
    .hold       (hold),
    .alu_res_lo (alu_res_lo),
    .alu_res_hi (alu_res_hi),
    .rs_data    (rs_data),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stall_req  (stall_req),
    .div_done   (div_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op);
    op_valid = 1'b1;
    op_code  = op;
  endtask

  task automatic idle_in();
    op_valid = 1'b0;
    op_code  = 3'd0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; hold = 1'b0;
    op_sub = 1'b0; rs_data = '0;
    alu_res_lo = '0; alu_res_hi = '0;
    idle_in();
    tick(); tick();
    rst = 1'b1;
    #1;
    vecs++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      errs++;
      $display("FAIL reset_hilo got %h:%h want 0:0",
               hi_o, lo_o);
    end
    vecs++;
    if (stall_req !== 1'b0 || div_done !== 1'b0) begin
      errs++;
      $display("FAIL reset_ctl got stall=%b done=%b want 0 0",
               stall_req, div_done);
    end
  endtask

  task automatic test_mult();
    alu_res_hi = 32'hFFFF_FFFF;
    alu_res_lo = 32'hFFFF_FFFE;
    issue(3'd1);
    #1;
    vecs++;
    if (stall_req !== 1'b0) begin
      errs++;
      $display("FAIL mult_stall got %b want 0", stall_req);
    end
    tick();
    idle_in();
    #1;
    vecs++;
    if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFE
        || stall_req !== 1'b0) begin
      errs++;
      $display("FAIL mult got %h:%h stall=%b want ffffffff:fffffffe 0",
               hi_o, lo_o, stall_req);
    end
    // MULTU under hold must not be accepted
    alu_res_hi = 32'h0000_0001;
    alu_res_lo = 32'h8000_0000;
    hold = 1'b1;
    issue(3'd2);
    tick();
    hold = 1'b0;
    idle_in();
    #1;
    vecs++;
    if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFE) begin
      errs++;
      $display("FAIL mult_hold got %h:%h want ffffffff:fffffffe",
               hi_o, lo_o);
    end
    issue(3'd2);
    tick();
    idle_in();
    #1;
    vecs++;
    if (hi_o !== 32'h0000_0001 || lo_o !== 32'h8000_0000) begin
      errs++;
      $display("FAIL multu got %h:%h want 00000001:80000000",
               hi_o, lo_o);
    end
  endtask

  task automatic test_mthi_mtlo();
    rs_data = 32'h1234_5678;
    issue(3'd5);
    tick();
    idle_in();
    #1;
    vecs++;
    if (hi_o !== 32'h1234_5678 || lo_o !== 32'h8000_0000) begin
      errs++;
      $display("FAIL mthi got %h:%h want 12345678:80000000",
               hi_o, lo_o);
    end
    rs_data = 32'h9ABC_DEF0;
    issue(3'd6);
    tick();
    idle_in();
    #1;
    vecs++;
    if (hi_o !== 32'h1234_5678 || lo_o !== 32'h9ABC_DEF0) begin
      errs++;
      $display("FAIL mtlo got %h:%h want 12345678:9abcdef0",
               hi_o, lo_o);
    end
  endtask

  task automatic test_divu();
    int bad = 0;
    alu_res_lo = 32'd7;
    alu_res_hi = 32'd3;
    issue(3'd4);
    #1;
    vecs++;
    if (stall_req !== 1'b0) begin
      errs++;
      $display("FAIL divu_c0_stall got %b want 0", stall_req);
    end
    tick();
    for (int c = 1; c <= 34; c++) begin
      if (c == 5) begin
        rs_data = 32'hDEAD_BEEF;
        issue(3'd5);
      end else begin
        idle_in();
      end
      #1;
      if (stall_req !== 1'b1 || div_done !== 1'b0) bad++;
      tick();
    end
    idle_in();
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL divu_busy %0d cycles off, want stall=1 done=0",
               bad);
    end
    #1;
    vecs++;
    if (stall_req !== 1'b0 || div_done !== 1'b1) begin
      errs++;
      $display("FAIL divu_c35 got stall=%b done=%b want 0 1",
               stall_req, div_done);
    end
    vecs++;
    if (hi_o !== 32'h1234_5678 || lo_o !== 32'h9ABC_DEF0) begin
      errs++;
      $display("FAIL divu_c35_hilo got %h:%h want 12345678:9abcdef0",
               hi_o, lo_o);
    end
    tick();
    #1;
    vecs++;
    if (hi_o !== 32'd3 || lo_o !== 32'd7 || div_done !== 1'b0) begin
      errs++;
      $display("FAIL divu_c36 got %h:%h done=%b want 3:7 0",
               hi_o, lo_o, div_done);
    end
  endtask

  task automatic test_flush();
    int bad = 0;
    alu_res_hi = 32'hAAAA_AAAA;
    alu_res_lo = 32'h5555_5555;
    issue(3'd3);
    tick();
    idle_in();
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    vecs++;
    if (stall_req !== 1'b0 || div_done !== 1'b0) begin
      errs++;
      $display("FAIL flush_ctl got stall=%b done=%b want 0 0",
               stall_req, div_done);
    end
    for (int c = 0; c < 40; c++) begin
      if (div_done !== 1'b0 || stall_req !== 1'b0) bad++;
      tick();
    end
    vecs++;
    if (bad != 0 || hi_o !== 32'd3 || lo_o !== 32'd7) begin
      errs++;
      $display("FAIL flush_after bad=%0d got %h:%h want 0 3:7",
               bad, hi_o, lo_o);
    end
    flush = 1'b1;
    rs_data = 32'h1111_1111;
    issue(3'd5);
    tick();
    flush = 1'b0;
    idle_in();
    #1;
    vecs++;
    if (hi_o !== 32'd3) begin
      errs++;
      $display("FAIL flush_drop got %h want 00000003", hi_o);
    end
  endtask

  task automatic test_hold_commit();
    int bad = 0;
    alu_res_hi = 32'h0000_0001;
    alu_res_lo = 32'hFFFF_0000;
    issue(3'd3);
    tick();
    idle_in();
    for (int c = 1; c <= 34; c++) tick();
    hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (stall_req !== 1'b1 || div_done !== 1'b0) bad++;
      tick();
    end
    vecs++;
    if (bad != 0 || hi_o !== 32'd3) begin
      errs++;
      $display("FAIL hold_commit bad=%0d hi=%h want 0 00000003",
               bad, hi_o);
    end
    hold = 1'b0;
    #1;
    vecs++;
    if (stall_req !== 1'b0 || div_done !== 1'b1) begin
      errs++;
      $display("FAIL hold_release got stall=%b done=%b want 0 1",
               stall_req, div_done);
    end
    tick();
    #1;
    vecs++;
    if (hi_o !== 32'h1 || lo_o !== 32'hFFFF_0000
        || div_done !== 1'b0) begin
      errs++;
      $display("FAIL hold_result got %h:%h done=%b want 1:ffff0000 0",
               hi_o, lo_o, div_done);
    end
  endtask

  task automatic test_back_to_back();
    alu_res_hi = 32'd9;
    alu_res_lo = 32'h20;
    issue(3'd4);
    tick();
    idle_in();
    for (int c = 1; c <= 35; c++) tick();
    vecs++;
    if (hi_o !== 32'd9 || lo_o !== 32'h20 || stall_req !== 1'b0) begin
      errs++;
      $display("FAIL b2b_div got %h:%h stall=%b want 9:20 0",
               hi_o, lo_o, stall_req);
    end
    alu_res_hi = 32'h0000_0BAD;
    alu_res_lo = 32'h0000_F00D;
    issue(3'd1);
    tick();
    idle_in();
    #1;
    vecs++;
    if (hi_o !== 32'h0BAD || lo_o !== 32'hF00D) begin
      errs++;
      $display("FAIL b2b_mult got %h:%h want bad:f00d", hi_o, lo_o);
    end
  endtask

  task automatic test_reset_mid_div();
    alu_res_hi = 32'h7777_7777;
    alu_res_lo = 32'h6666_6666;
    issue(3'd3);
    tick();
    idle_in();
    for (int c = 1; c < 10; c++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    vecs++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0 || stall_req !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid got %h:%h stall=%b want 0:0 0",
               hi_o, lo_o, stall_req);
    end
    for (int c = 0; c < 30; c++) tick();
    vecs++;
    if (hi_o !== 32'h0 || div_done !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_after got hi=%h done=%b want 0 0",
               hi_o, div_done);
    end
  endtask

  task automatic test_madd();
    logic [31:0] e1_hi, e1_lo, e2_hi, e2_lo;
`ifdef MADD_MSUB_EN
    e1_hi = 32'h1; e1_lo = 32'h0;
    e2_hi = 32'h0; e2_lo = 32'hFFFF_FFFF;
`else
    e1_hi = 32'h0; e1_lo = 32'hFFFF_FFFF;
    e2_hi = 32'h0; e2_lo = 32'hFFFF_FFFF;
`endif
    rs_data = 32'h0;
    issue(3'd5);
    tick();
    rs_data = 32'hFFFF_FFFF;
    issue(3'd6);
    tick();
    alu_res_hi = 32'h0;
    alu_res_lo = 32'h1;
    op_sub = 1'b0;
    issue(3'd7);
    #1;
    vecs++;
    if (stall_req !== 1'b0) begin
      errs++;
      $display("FAIL madd_stall got %b want 0", stall_req);
    end
    tick();
    idle_in();
    #1;
    vecs++;
    if (hi_o !== e1_hi || lo_o !== e1_lo) begin
      errs++;
      $display("FAIL madd got %h:%h want %h:%h",
               hi_o, lo_o, e1_hi, e1_lo);
    end
    op_sub = 1'b1;
    issue(3'd7);
    tick();
    idle_in();
    op_sub = 1'b0;
    #1;
    vecs++;
    if (hi_o !== e2_hi || lo_o !== e2_lo) begin
      errs++;
      $display("FAIL msub got %h:%h want %h:%h",
               hi_o, lo_o, e2_hi, e2_lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mthi_mtlo();
    test_divu();
    test_flush();
    test_hold_commit();
    test_back_to_back();
    test_reset_mid_div();
    test_madd();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
